regfile_wb_arbiter: RTL and testbench

Controller that shares the register file's single write port (WE3/A3/WD3) between the single-cycle core writeback path and a multi-cycle unit (load/divider) writeback stream. Buffers multi-cycle results in a small FIFO and arbitrates with starvation protection. Keeps a per-register busy scoreboard so the core stalls on reads of, or writes to, registers with a pending multi-cycle result. Sits between the core's writeback stage, the multi-cycle unit and Register_File.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_if.sv | 29 ++
 rtl/wb_fifo.sv | 38 +++
 rtl/regfile_wb_arbiter.sv | 57 +++++
 tb/tb_regfile_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, defaults, grant encoding and FIFO entry type for the writeback arbiter
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam int NREG = 1 << REG_AW;
  localparam int FIFO_DEPTH_D = 2;
  localparam int STARVE_LIMIT_D = 4;
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_CORE = 2'd1, GNT_MC = 2'd2} gnt_e;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0] wd;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: core, multi-cycle unit and register-file write port signals
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;
  logic core_we;
  logic [REG_AW-1:0] core_rd;
  logic [XLEN-1:0] core_wd;
  logic core_stall;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic rs1_busy;
  logic rs2_busy;
  logic mc_issue;
  logic [REG_AW-1:0] mc_issue_rd;
  logic mc_valid;
  logic [REG_AW-1:0] mc_rd;
  logic [XLEN-1:0] mc_wd;
  logic mc_ready;
  logic rf_we;
  logic [REG_AW-1:0] rf_a3;
  logic [XLEN-1:0] rf_wd;
  modport slave (
    input core_we, core_rd, core_wd, rs1, rs2, mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_wd,
    output core_stall, rs1_busy, rs2_busy, mc_ready, rf_we, rf_a3, rf_wd
  );
  modport master (
    output core_we, core_rd, core_wd, rs1, rs2, mc_issue, mc_issue_rd, mc_valid, mc_rd, mc_wd,
    input core_stall, rs1_busy, rs2_busy, mc_ready, rf_we, rf_a3, rf_wd
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO buffering multi-cycle writeback entries
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == FULL;
  assign o_empty = r_cnt == '0;
  assign o_head = r_mem[r_rp];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_wdata;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between core and multi-cycle writebacks,
// with starvation protection and a busy scoreboard driving core stalls
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_D,
  parameter int STARVE_LIMIT = STARVE_LIMIT_D
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  wb_entry_t w_head;
  logic w_full, w_empty, w_push, w_pop, w_waw;
  gnt_e w_gnt;
  logic [SW-1:0] r_starve;
  logic [NREG-1:0] r_busy, w_busy_nxt;
  assign bus.mc_ready = !rst && !w_full;
  assign w_push = bus.mc_valid && bus.mc_ready;
  assign w_gnt = (!w_empty && (!bus.core_we || r_starve == LIMIT)) ? GNT_MC :
                 bus.core_we ? GNT_CORE : GNT_NONE;
  assign w_pop = w_gnt == GNT_MC;
  wb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(wb_entry_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_wdata({bus.mc_rd, bus.mc_wd}),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_head(w_head)
  );
  // Writes to x0 still consume their grant (and pop), they just never assert WE3
  assign bus.rf_we = !rst && (w_pop ? w_head.rd != '0 : w_gnt == GNT_CORE && bus.core_rd != '0);
  assign bus.rf_a3 = w_pop ? w_head.rd : w_gnt == GNT_CORE ? bus.core_rd : '0;
  assign bus.rf_wd = w_pop ? w_head.wd : w_gnt == GNT_CORE ? bus.core_wd : '0;
  assign bus.rs1_busy = r_busy[bus.rs1] && bus.rs1 != '0;
  assign bus.rs2_busy = r_busy[bus.rs2] && bus.rs2 != '0;
  assign w_waw = bus.core_we && r_busy[bus.core_rd] && bus.core_rd != '0;
  assign bus.core_stall = (bus.core_we && w_pop) || w_waw || bus.rs1_busy || bus.rs2_busy;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_starve <= '0;
    else r_starve <= (w_empty || w_pop) ? '0 :
                     (w_gnt == GNT_CORE && r_starve != LIMIT) ? r_starve + 1'b1 : r_starve;
  // A new issue to the register being retired this cycle keeps it busy
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head.rd] = 1'b0;
    if (bus.mc_issue) w_busy_nxt[bus.mc_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_busy <= '0;
    else r_busy <= w_busy_nxt;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus randomized traffic checked against a queue-based model
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int STARVE = 4;
  typedef struct packed {
    logic [4:0] rd;
    logic [31:0] wd;
  } ent_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  ent_t q[$];
  bit [31:0] m_busy;
  int m_starve;
  bit e_mc, e_core, e_we, e_stall, e_b1, e_b2, e_ready;
  logic [4:0] e_a3;
  logic [31:0] e_wd;
  always #5 clk = ~clk;
  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic model_reset();
    q.delete();
    m_busy = '0;
    m_starve = 0;
  endtask

  task automatic compute_expect();
    e_mc = q.size() > 0 && (!bus.core_we || m_starve == STARVE);
    e_core = !e_mc && bus.core_we;
    e_we = e_mc ? (q[0].rd != 0) : (e_core && bus.core_rd != 0);
    e_a3 = e_mc ? q[0].rd : e_core ? bus.core_rd : 5'd0;
    e_wd = e_mc ? q[0].wd : e_core ? bus.core_wd : 32'd0;
    e_b1 = m_busy[bus.rs1] && bus.rs1 != 0;
    e_b2 = m_busy[bus.rs2] && bus.rs2 != 0;
    e_stall = (bus.core_we && e_mc) || (bus.core_we && m_busy[bus.core_rd] && bus.core_rd != 0) || e_b1 || e_b2;
    e_ready = q.size() < DEPTH;
  endtask

  task automatic model_update();
    bit push;
    compute_expect();
    push = bus.mc_valid && q.size() < DEPTH;
    if (q.size() == 0 || e_mc) m_starve = 0;
    else if (e_core && m_starve < STARVE) m_starve++;
    if (e_mc) begin
      m_busy[q[0].rd] = 1'b0;
      q.delete(0);
    end
    if (push) q.push_back('{rd: bus.mc_rd, wd: bus.mc_wd});
    if (bus.mc_issue) m_busy[bus.mc_issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    bus.core_we = 0; bus.core_rd = 0; bus.core_wd = 0; bus.rs1 = 0; bus.rs2 = 0;
    bus.mc_issue = 0; bus.mc_issue_rd = 0; bus.mc_valid = 0; bus.mc_rd = 0; bus.mc_wd = 0;
  endtask

  task automatic test_reset();
    bus.core_we = 1; bus.core_rd = 5'd5; bus.core_wd = 32'h1111_2222; bus.mc_valid = 1; bus.rs1 = 5'd3;
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0b exp 0", bus.rf_we); end
    checks++; if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL reset_mc_ready got %0b exp 0", bus.mc_ready); end
    checks++; if (bus.core_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", bus.core_stall); end
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_rs1_busy got %0b exp 0", bus.rs1_busy); end
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b exp 1", bus.mc_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL post_reset_rf_we got %0b exp 0", bus.rf_we); end
    tick();
  endtask

  task automatic test_core_write();
    bus.core_we = 1; bus.core_rd = 5'd5; bus.core_wd = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd5, 32'hDEAD_BEEF})
      begin errors++; $display("FAIL core_write got we=%0b a3=%0d wd=%h exp we=1 a3=5 wd=deadbeef", bus.rf_we, bus.rf_a3, bus.rf_wd); end
    checks++; if (bus.core_stall !== 1'b0) begin errors++; $display("FAIL core_write_stall got %0b exp 0", bus.core_stall); end
    tick();
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    bus.mc_issue = 1; bus.mc_issue_rd = 5'd7;
    tick();
    bus.mc_issue = 0; bus.rs1 = 5'd7;
    bus.mc_valid = 1; bus.mc_rd = 5'd7; bus.mc_wd = 32'h1234;
    @(negedge clk);
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_rs1_busy got %0b exp 1", bus.rs1_busy); end
    checks++; if (bus.core_stall !== 1'b1) begin errors++; $display("FAIL sb_stall got %0b exp 1", bus.core_stall); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL sb_no_bypass got %0b exp 0", bus.rf_we); end
    tick();
    bus.mc_valid = 0;
    @(negedge clk);
    checks++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 5'd7, 32'h1234})
      begin errors++; $display("FAIL sb_mc_write got we=%0b a3=%0d wd=%h exp we=1 a3=7 wd=1234", bus.rf_we, bus.rf_a3, bus.rf_wd); end
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_on_pop got %0b exp 1", bus.rs1_busy); end
    tick();
    @(negedge clk);
    checks++; if (bus.rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_cleared got %0b exp 0", bus.rs1_busy); end
    tick();
    idle_inputs();
  endtask

  task automatic test_starvation();
    bus.core_we = 1; bus.core_rd = 5'd4; bus.core_wd = 32'h4444;
    bus.mc_valid = 1; bus.mc_rd = 5'd3; bus.mc_wd = 32'hAA;
    tick();
    bus.mc_valid = 0;
    for (int i = 0; i < STARVE; i++) begin
      @(negedge clk);
      checks++; if (bus.rf_a3 !== 5'd4 || bus.rf_we !== 1'b1)
        begin errors++; $display("FAIL starve_core_%0d got we=%0b a3=%0d exp we=1 a3=4", i, bus.rf_we, bus.rf_a3); end
      tick();
    end
    @(negedge clk);
    checks++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd, bus.core_stall} !== {1'b1, 5'd3, 32'hAA, 1'b1})
      begin errors++; $display("FAIL starve_forced got we=%0b a3=%0d wd=%h stall=%0b exp 1 3 aa 1", bus.rf_we, bus.rf_a3, bus.rf_wd, bus.core_stall); end
    tick();
    @(negedge clk);
    checks++; if ({bus.rf_a3, bus.core_stall} !== {5'd4, 1'b0})
      begin errors++; $display("FAIL starve_after got a3=%0d stall=%0b exp 4 0", bus.rf_a3, bus.core_stall); end
    tick();
    idle_inputs();
  endtask

  task automatic test_full();
    bus.core_we = 1; bus.core_rd = 5'd4;
    bus.mc_valid = 1; bus.mc_rd = 5'd10; bus.mc_wd = 32'hA0;
    tick();
    bus.mc_rd = 5'd11; bus.mc_wd = 32'hA1;
    tick();
    bus.core_we = 0; bus.mc_rd = 5'd12; bus.mc_wd = 32'hA2;
    @(negedge clk);
    checks++; if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", bus.mc_ready); end
    checks++; if (bus.rf_a3 !== 5'd10) begin errors++; $display("FAIL full_pop0 got a3=%0d exp 10", bus.rf_a3); end
    tick();
    @(negedge clk);
    checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL full_ready_again got %0b exp 1", bus.mc_ready); end
    checks++; if (bus.rf_a3 !== 5'd11 || bus.rf_wd !== 32'hA1) begin errors++; $display("FAIL full_pop1 got a3=%0d wd=%h exp 11 a1", bus.rf_a3, bus.rf_wd); end
    bus.mc_valid = 0;
    tick();
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL full_no_third got we=%0b a3=%0d exp we=0", bus.rf_we, bus.rf_a3); end
    tick();
    idle_inputs();
  endtask

  task automatic test_zero();
    bus.core_we = 1; bus.core_rd = 5'd0; bus.core_wd = 32'h55;
    bus.mc_valid = 1; bus.mc_rd = 5'd0; bus.mc_wd = 32'h66;
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL zero_core got %0b exp 0", bus.rf_we); end
    tick();
    bus.core_we = 0; bus.mc_valid = 0; bus.mc_issue = 1; bus.mc_issue_rd = 5'd0;
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL zero_mc got %0b exp 0", bus.rf_we); end
    tick();
    bus.mc_issue = 0; bus.core_we = 1; bus.core_rd = 5'd6;
    @(negedge clk);
    checks++; if (bus.rf_a3 !== 5'd6 || bus.core_stall !== 1'b0)
      begin errors++; $display("FAIL zero_popped got a3=%0d stall=%0b exp 6 0", bus.rf_a3, bus.core_stall); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.core_we = 1; bus.core_rd = 5'd4;
    bus.mc_valid = 1; bus.mc_rd = 5'd9; bus.mc_wd = 32'h99;
    bus.mc_issue = 1; bus.mc_issue_rd = 5'd9;
    tick();
    bus.mc_rd = 5'd8; bus.mc_issue = 0;
    tick();
    bus.rs1 = 5'd9;
    rst = 1;
    #1;
    checks++; if ({bus.rf_we, bus.mc_ready, bus.rs1_busy} !== 3'b000)
      begin errors++; $display("FAIL mid_reset got we=%0b ready=%0b busy=%0b exp 0 0 0", bus.rf_we, bus.mc_ready, bus.rs1_busy); end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    bus.mc_valid = 0;
    @(negedge clk);
    checks++; if ({bus.rs1_busy, bus.mc_ready, bus.rf_a3} !== {1'b0, 1'b1, 5'd4})
      begin errors++; $display("FAIL mid_release got busy=%0b ready=%0b a3=%0d exp 0 1 4", bus.rs1_busy, bus.mc_ready, bus.rf_a3); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [4:0] ird;
    for (int n = 0; n < 400; n++) begin
      bus.core_we = 1'($urandom_range(0, 3) != 0);
      bus.core_rd = 5'($urandom_range(0, 7));
      bus.core_wd = $urandom;
      bus.rs1 = 5'($urandom_range(0, 7));
      bus.rs2 = 5'($urandom_range(0, 7));
      bus.mc_valid = 1'($urandom_range(0, 1));
      bus.mc_rd = 5'($urandom_range(0, 7));
      bus.mc_wd = $urandom;
      ird = 5'($urandom_range(0, 7));
      bus.mc_issue_rd = ird;
      bus.mc_issue = $urandom_range(0, 3) == 0 && !m_busy[ird];
      @(negedge clk);
      compute_expect();
      checks++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {e_we, e_a3, e_wd})
        begin errors++; $display("FAIL rnd_wb[%0d] got we=%0b a3=%0d wd=%h exp we=%0b a3=%0d wd=%h", n, bus.rf_we, bus.rf_a3, bus.rf_wd, e_we, e_a3, e_wd); end
      checks++; if ({bus.core_stall, bus.rs1_busy, bus.rs2_busy, bus.mc_ready} !== {e_stall, e_b1, e_b2, e_ready})
        begin errors++; $display("FAIL rnd_ctl[%0d] got stall/b1/b2/ready=%b%b%b%b exp %b%b%b%b", n, bus.core_stall, bus.rs1_busy, bus.rs2_busy, bus.mc_ready, e_stall, e_b1, e_b2, e_ready); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_core_write();
    test_scoreboard();
    test_starvation();
    test_full();
    test_zero();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
